// File: rtl/seq_player.sv
// seq_player: presents a captured pattern MSB first, each bit held ON_CYCLES then blanked for GAP_CYCLES.
module seq_player #(
    parameter int SEQ_W      = 16,
    parameter int ON_CYCLES  = 50000000,
    parameter int GAP_CYCLES = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SEQ_W-1:0] seq,
    input  logic [4:0]       len,
    output logic             led_valid,
    output logic             led_bit,
    output logic [3:0]       idx,
    output logic             busy,
    output logic             done
);
    localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

    state_t          state, state_n;
    logic [SEQ_W-1:0] pat, pat_n;
    logic [4:0]       len_r, len_n, len_cap;
    logic [3:0]       idx_r, idx_n;
    logic [TW-1:0]    tmr, tmr_n;

    assign len_cap   = (len > 5'(SEQ_W)) ? 5'(SEQ_W) : len;
    assign led_valid = (state == SHOW);
    assign led_bit   = (state == SHOW) & pat[SEQ_W-1];
    assign idx       = idx_r;
    assign busy      = (state == SHOW) || (state == GAP);
    assign done      = (state == DONE);

    // state and datapath registers; the pattern is shifted so the shown bit is always the MSB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pat   <= '0;
            len_r <= '0;
            idx_r <= '0;
            tmr   <= '0;
        end else begin
            state <= state_n;
            pat   <= pat_n;
            len_r <= len_n;
            idx_r <= idx_n;
            tmr   <= tmr_n;
        end
    end

    // next-state: capture on start, time each bit and gap, finish after the last bit without a gap
    always_comb begin
        state_n = state;
        pat_n   = pat;
        len_n   = len_r;
        idx_n   = idx_r;
        tmr_n   = tmr;
        case (state)
            IDLE: if (start) begin
                pat_n   = seq;
                len_n   = len_cap;
                idx_n   = '0;
                tmr_n   = '0;
                state_n = (len_cap == 5'd0) ? DONE : SHOW;
            end
            SHOW: begin
                tmr_n = tmr + TW'(1);
                if (tmr == ON_LAST) begin
                    tmr_n   = '0;
                    state_n = ({1'b0, idx_r} == len_r - 5'd1) ? DONE : GAP;
                end
            end
            GAP: begin
                tmr_n = tmr + TW'(1);
                if (tmr == GAP_LAST) begin
                    tmr_n   = '0;
                    idx_n   = idx_r + 4'd1;
                    pat_n   = pat << 1;
                    state_n = SHOW;
                end
            end
            DONE: begin
                idx_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: random and directed playback checked against a frame-timeline reference model.
module tb_seq_player;
    localparam int ON  = 3;
    localparam int GAP = 2;

    logic        clk = 0, reset = 1, start = 0;
    logic [15:0] seq = '0;
    logic [4:0]  len = '0;
    logic        led_valid, led_bit, busy, done;
    logic [3:0]  idx;

    typedef struct packed {
        logic       v;
        logic       b;
        logic [3:0] i;
        logic       bz;
        logic       d;
    } frame_t;

    frame_t q[$];
    int n_cmp = 0, n_bad = 0;

    seq_player #(.SEQ_W(16), .ON_CYCLES(ON), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .seq(seq), .len(len),
        .led_valid(led_valid), .led_bit(led_bit), .idx(idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // expected outputs for a whole playback, one frame per clock cycle
    function automatic void load(input logic [15:0] s, input logic [4:0] l);
        int n = (l > 16) ? 16 : int'(l);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < ON; k++) q.push_back('{1'b1, s[15-i], 4'(i), 1'b1, 1'b0});
            if (i < n - 1)
                for (int k = 0; k < GAP; k++) q.push_back('{1'b0, 1'b0, 4'(i), 1'b1, 1'b0});
        end
        q.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b1});
    endfunction

    task automatic step();
        frame_t e;
        bit was_idle;
        @(posedge clk);
        was_idle = (q.size() == 0);
        if (!was_idle) void'(q.pop_front());
        if (was_idle && start && reset) load(seq, len);
        @(negedge clk);
        e = (q.size() != 0) ? q[0] : '0;
        check("led_valid", int'(led_valid), int'(e.v));
        check("led_bit", int'(led_bit), int'(e.b));
        check("busy", int'(busy), int'(e.bz));
        check("done", int'(done), int'(e.d));
        if (!e.d) check("idx", int'(idx), int'(e.i));
    endtask

    task automatic run_count(input logic [15:0] s, input logic [4:0] l, input int exp_busy);
        int b = 0, c = 1;
        seq = s; len = l; start = 1;
        step();
        start = 0;
        while (!done && c < 200) begin
            if (busy) b++;
            step();
            c++;
        end
        check("busy_cycles", b, exp_busy);
        check("done_cycle", c, exp_busy + 1);
        step();
    endtask

    initial begin
        int c;
        #1 reset = 0;
        #1;
        check("rst_valid", int'(led_valid), 0);
        check("rst_bit", int'(led_bit), 0);
        check("rst_idx", int'(idx), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        step();

        run_count(16'b1001011010101011, 5'd16, 78);
        run_count(16'h8000, 5'd1, 3);
        run_count(16'hFFFF, 5'd0, 0);
        run_count(16'b1001011010101011, 5'd20, 78);

        // restart attempt with a cleared pattern mid-playback
        seq = 16'hA5C3; len = 5'd8; start = 1;
        step();
        start = 0;
        for (int k = 0; k < 10; k++) step();
        seq = 16'h0000; start = 1;
        step();
        start = 0;
        for (int k = 0; k < 40; k++) step();

        // asynchronous abort during bit 5
        seq = 16'h5A5A; len = 5'd16; start = 1;
        step();
        start = 0;
        c = 0;
        while (!(led_valid && idx == 4'd5) && c < 200) begin
            step();
            c++;
        end
        check("reach_idx5", c < 200 ? 1 : 0, 1);
        #2 reset = 0;
        #1;
        check("abort_valid", int'(led_valid), 0);
        check("abort_bit", int'(led_bit), 0);
        check("abort_idx", int'(idx), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        q.delete();
        step();
        step();
        reset = 1; start = 1; seq = 16'hC001; len = 5'd4;
        step();
        start = 0;
        check("restart_idx0", int'(idx), 0);
        while (!done && c < 400) begin
            step();
            c++;
        end
        step();
        start = 1; seq = 16'h8421; len = 5'd3;
        step();
        start = 0;
        check("b2b_valid", int'(led_valid), 1);
        for (int k = 0; k < 30; k++) step();

        for (int k = 0; k < 2000; k++) begin
            start = ($urandom_range(0, 9) == 0);
            seq = 16'($urandom);
            len = 5'($urandom_range(0, 20));
            step();
        end
        start = 0;
        for (int k = 0; k < 100; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
